shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller that shares one external 8-bit left-shift unit between two requesters.
- Arbitrates round-robin, splits shift amounts 0..15 into passes of up to 7, and performs logical right shifts by bit-reversing the operand and the result.
- Sits between the execute-stage requesters and the Shifter instance. Drives the shifter's amount/operand inputs and consumes its combinational result.

Parameters:
- DATA_W, 8, operand/result width; must match the shifter.
- SH_AMT_W, 3, shifter amount width; maximum step per pass is 2^SH_AMT_W-1 = 7.
- REQ_AMT_W, 4, requested shift amount width (0..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a shift request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_data  input  DATA_W  operand from requester 0
- req0_amt  input  REQ_AMT_W  shift amount from requester 0
- req0_dir  input  1  requester 0 direction: 0 = left, 1 = logical right
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same widths and meanings for requester 1
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  DATA_W  shifted result
- resp_id  output  1  requester index that owns resp_data
- sh_a  output  SH_AMT_W  amount to shifter
- sh_b  output  DATA_W  operand to shifter
- sh_result  input  DATA_W  shifter output (combinational, same cycle)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n. All state is clocked on rising clk.
- Reset values:
  - state = IDLE; rr_ptr = 0; work, rem, id, dir = 0.
  - All outputs 0: resp_valid, resp_data, resp_id, req*_ready, sh_a, sh_b, busy.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant rule:
    - Only one valid request: grant it.
    - Both valid: grant the requester indicated by rr_ptr.
  - req_ready is combinational; it is high only in IDLE, only for the granted requester, and only while that requester's valid is high.
  - On the accepting edge, latch:
    - id = grant;
    - dir;
    - rem = amt;
    - work = data if dir=0, else bit-reverse(data).
  - Next state: SHIFT if amt != 0, else DONE.
- SHIFT:
  - step = min(rem, 7); sh_a = step; sh_b = work.
  - Each cycle: work <= sh_result; rem <= rem - step.
  - Go to DONE when rem - step == 0.
  - Pass count = ceil(amt/7): amt 1..7 takes 1 pass, 8..14 takes 2, 15 takes 3 (steps 7, 7, 1).
  - Outside SHIFT, sh_a = 0 and sh_b = 0.
- DONE:
  - resp_valid = 1; resp_id = id.
  - resp_data = work if dir=0, else bit-reverse(work).
  - resp_data and resp_id are registered and held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready: go to IDLE; rr_ptr <= ~id.
- Latency from the accept edge T:
  - resp_valid is high in cycle T+1+passes.
  - amt = 0 gives resp_valid in T+1, with data unchanged.
- No new request is accepted before the current response is consumed. Back-to-back accept is possible in the cycle after the response handshake.
- A request that drops valid before it is accepted is simply not accepted; no latching occurs.
- Input changes after acceptance have no effect on the operation in flight.
- Reset mid-operation (any state): immediate abort, all values return to reset values, no response is issued.
- Right shift by 8..15 always yields 0. Left shift likewise yields 0 once all bits are shifted out. No arithmetic-right mode.

Test Plan:
- req0: data=0x81, amt=3, dir=0 -> one SHIFT cycle with sh_a=3, sh_b=0x81; then resp_data=0x08, resp_id=0 at T+2.
- req1: data=0xF0, amt=4, dir=1 -> sh_b=0x0F (reversed), sh_a=4; then resp_data=0x0F, resp_id=1 at T+2.
- req0: data=0x01, amt=15, dir=0 -> sh_a sequence 7, 7, 1 over three cycles; resp_data=0x00 at T+4. Repeat with amt=9 and data=0x01 -> resp_data=0x00 after passes 7, 2; amt=6 -> resp_data=0x40.
- req0: amt=0, data=0x5A -> no SHIFT cycle, sh_a stays 0; resp_data=0x5A at T+1.
- Contention:
  - Both requesters valid continuously after reset -> grants in order req0, req1, req0, req1.
  - With only req1 valid, req1 is granted regardless of rr_ptr.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, resp_data and resp_id stay stable and req*_ready stay 0. Then pulse rst_n low during SHIFT of an amt=15 request -> all outputs 0 immediately, state IDLE, no response; the next request completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shares one external left-shift unit between two requesters; splits large amounts into
// passes of at most 2^SH_AMT_W-1 and handles logical right shifts via operand bit reversal.
module shift_sequencer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SH_AMT_W  = 3,
    parameter int unsigned REQ_AMT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic [REQ_AMT_W-1:0] req0_amt,
    input  logic                 req0_dir,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_W-1:0]    req1_data,
    input  logic [REQ_AMT_W-1:0] req1_amt,
    input  logic                 req1_dir,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_data,
    output logic                 resp_id,
    output logic [SH_AMT_W-1:0]  sh_a,
    output logic [DATA_W-1:0]    sh_b,
    input  logic [DATA_W-1:0]    sh_result,
    output logic                 busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [REQ_AMT_W-1:0] MAX_STEP = REQ_AMT_W'((1 << SH_AMT_W) - 1);

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    logic [1:0]           state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]    work_q, work_d;
    logic [REQ_AMT_W-1:0] rem_q, rem_d;
    logic                 id_q, id_d;
    logic                 dir_q, dir_d;
    logic [DATA_W-1:0]    resp_data_q, resp_data_d;
    logic                 resp_id_q, resp_id_d;

    logic                 grant;
    logic                 idle;
    logic [DATA_W-1:0]    sel_data;
    logic [REQ_AMT_W-1:0] sel_amt;
    logic                 sel_dir;
    logic [SH_AMT_W-1:0]  step;
    logic [REQ_AMT_W-1:0] rem_next;

    always_comb begin
        grant      = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        // Ready is combinational, so gate it with reset to keep all outputs low during reset.
        idle       = (state_q == IDLE) && rst_n;
        req0_ready = idle && req0_valid && !grant;
        req1_ready = idle && req1_valid && grant;

        sel_data = grant ? req1_data : req0_data;
        sel_amt  = grant ? req1_amt  : req0_amt;
        sel_dir  = grant ? req1_dir  : req0_dir;

        step     = (rem_q > MAX_STEP) ? MAX_STEP[SH_AMT_W-1:0] : rem_q[SH_AMT_W-1:0];
        rem_next = rem_q - REQ_AMT_W'(step);

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        work_d      = work_q;
        rem_d       = rem_q;
        id_d        = id_q;
        dir_d       = dir_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        sh_a        = '0;
        sh_b        = '0;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    id_d   = grant;
                    dir_d  = sel_dir;
                    rem_d  = sel_amt;
                    work_d = sel_dir ? bit_rev(sel_data) : sel_data;
                    if (sel_amt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        // Zero amount: result equals the operand in either direction.
                        state_d     = DONE;
                        resp_data_d = sel_data;
                        resp_id_d   = grant;
                    end
                end
            end
            SHIFT: begin
                sh_a   = step;
                sh_b   = work_q;
                work_d = sh_result;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d     = DONE;
                    resp_data_d = dir_q ? bit_rev(sh_result) : sh_result;
                    resp_id_d   = id_q;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d     = IDLE;
                    rr_ptr_d    = ~id_q;
                    resp_data_d = '0;
                    resp_id_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            work_q      <= '0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            dir_q       <= 1'b0;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            id_q        <= id_d;
            dir_q       <= dir_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases with literal expectations plus random traffic,
// all outputs compared every cycle against a schedule-level reference model.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [3:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [3:0] req1_amt;
    logic       resp_valid, resp_ready, resp_id, busy;
    logic [7:0] resp_data, sh_b, sh_result;
    logic [2:0] sh_a;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .sh_a       (sh_a),
        .sh_b       (sh_b),
        .sh_result  (sh_result),
        .busy       (busy)
    );

    // External shifter: plain 8-bit left shift.
    assign sh_result = sh_b << sh_a;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Reference model: each accepted request expands into a schedule of passes then a result.
    logic       m_active = 1'b0;
    logic       m_rr = 1'b0;
    logic       m_id = 1'b0;
    int         m_amt = 0;
    int         m_passes = 0;
    int         m_k = 0;
    logic [7:0] m_op = '0;
    logic [7:0] m_res = '0;

    always @(negedge clk) begin
        logic       g, dr, e_rv, e_id, e_busy, e_r0, e_r1;
        logic [7:0] d, e_data, e_shb;
        logic [3:0] a;
        int         e_sha, left, tmp;
        e_rv = 0; e_id = 0; e_busy = 0; e_r0 = 0; e_r1 = 0;
        e_data = '0; e_shb = '0; e_sha = 0;
        if (!rst_n) begin
            m_active = 0;
            m_rr     = 0;
        end else if (!m_active) begin
            g    = (req0_valid && req1_valid) ? m_rr : req1_valid;
            e_r0 = req0_valid && !g;
            e_r1 = req1_valid && g;
            if (req0_valid || req1_valid) begin
                d        = g ? req1_data : req0_data;
                a        = g ? req1_amt : req0_amt;
                dr       = g ? req1_dir : req0_dir;
                m_id     = g;
                m_amt    = int'(a);
                m_passes = (m_amt + 6) / 7;
                m_op     = dr ? rev8(d) : d;
                tmp      = int'(d) << m_amt;
                m_res    = dr ? (d >> a) : tmp[7:0];
                m_k      = 1;
                m_active = 1;
            end
        end else if (m_k <= m_passes) begin
            e_busy = 1;
            left   = m_amt - 7 * (m_k - 1);
            e_sha  = (left > 7) ? 7 : left;
            tmp    = int'(m_op) << (7 * (m_k - 1));
            e_shb  = tmp[7:0];
            m_k++;
        end else begin
            e_busy = 1;
            e_rv   = 1;
            e_data = m_res;
            e_id   = m_id;
            if (resp_ready) begin
                m_active = 0;
                m_rr     = !m_id;
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("resp_data", 32'(resp_data), 32'(e_data));
        chk("resp_id", 32'(resp_id), 32'(e_id));
        chk("sh_a", 32'(sh_a), 32'(e_sha));
        chk("sh_b", 32'(sh_b), 32'(e_shb));
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    end

    task automatic set_req(input bit who, input logic v, input logic [7:0] d, input logic [3:0] a,
                           input logic dr);
        if (who) begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dr;
        end else begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dr;
        end
    endtask

    task automatic wait_accept(input bit who);
        logic got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
        end
        chk("accept", 32'(got), 32'd1);
    endtask

    // Called at posedge+1; exp_lat counts cycles after the accept edge until resp_valid,
    // exp_seq packs the expected sh_a of pass i at bits [3i+2:3i].
    task automatic do_req(input bit who, input logic [7:0] d, input logic [3:0] a, input logic dr,
                          input logic [7:0] exp_d, input int exp_lat, input logic [8:0] exp_seq,
                          input logic [7:0] exp_shb0, input int hold);
        logic       got = 0;
        int         lat = 0;
        logic [8:0] seq = '0;
        logic [7:0] shb0 = '0;
        set_req(who, 1'b1, d, a, dr);
        wait_accept(who);
        @(posedge clk); #1;
        set_req(who, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom));
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            got = resp_valid;
            if (!got && lat <= 3) seq[3*(lat-1) +: 3] = sh_a;
            if (!got && lat == 1) shb0 = sh_b;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", 32'(resp_data), 32'(exp_d));
        chk("owner", 32'(resp_id), 32'(who));
        chk("sh_a_seq", 32'(seq), 32'(exp_seq));
        if (exp_lat > 1) chk("sh_b_first", 32'(shb0), 32'(exp_shb0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", 32'(resp_data), 32'(exp_d));
            chk("hold_id", 32'(resp_id), 32'(who));
            chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic got;
        logic [3:0] order;
        rst_n = 1'b0;
        resp_ready = 1'b0;
        set_req(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        set_req(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({resp_valid, resp_id, busy, req0_ready, req1_ready}), 32'd0);
        chk("rst_data", 32'({resp_data, sh_b, sh_a}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 8'h81, 4'd3,  1'b0, 8'h08, 2, 9'h003, 8'h81, 0);
        do_req(1'b1, 8'hF0, 4'd4,  1'b1, 8'h0F, 2, 9'h004, 8'h0F, 0);
        do_req(1'b0, 8'h01, 4'd15, 1'b0, 8'h00, 4, 9'h07F, 8'h01, 0);
        do_req(1'b0, 8'h01, 4'd9,  1'b0, 8'h00, 3, 9'h017, 8'h01, 0);
        do_req(1'b0, 8'h01, 4'd6,  1'b0, 8'h40, 2, 9'h006, 8'h01, 0);
        do_req(1'b0, 8'h5A, 4'd0,  1'b0, 8'h5A, 1, 9'h000, 8'h00, 0);
        do_req(1'b1, 8'hC3, 4'd2,  1'b1, 8'h30, 2, 9'h002, 8'hC3, 5);
        do_req(1'b1, 8'hFF, 4'd8,  1'b1, 8'h00, 3, 9'h00F, 8'hFF, 0);

        // Contention: rr pointer is back at requester 0 here.
        set_req(1'b0, 1'b1, 8'h3C, 4'd5, 1'b0);
        set_req(1'b1, 1'b1, 8'h3C, 4'd5, 1'b1);
        order = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            got = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = resp_valid;
            end
            chk("rr_resp", 32'(got), 32'd1);
            chk("rr_order", 32'(resp_id), 32'(order[i]));
            @(posedge clk); #1;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 8'h80, 4'd7, 1'b1, 8'h01, 2, 9'h007, 8'h01, 0);

        // Abort during the first pass of a long shift.
        set_req(1'b0, 1'b1, 8'h01, 4'd15, 1'b0);
        wait_accept(1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({resp_valid, resp_id, busy, req0_ready, req1_ready}), 32'd0);
        chk("abort_data", 32'({resp_data, sh_b, sh_a}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resp_after_abort", 32'({resp_valid, busy}), 32'd0);
        end
        @(posedge clk); #1;
        do_req(1'b0, 8'h01, 4'd6, 1'b0, 8'h40, 2, 9'h006, 8'h01, 0);

        repeat (600) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_data  = 8'($urandom);
            req0_amt   = 4'($urandom);
            req0_dir   = 1'($urandom);
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_data  = 8'($urandom);
            req1_amt   = 4'($urandom);
            req1_dir   = 1'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
